// File: rtl/dot_arbiter.sv
// Round-robin front end that shares one pipelined dot_product engine among NREQ
// requesters and returns results in issue order. Optional checker: DOT_ARB_CHECK_EN.
module dot_arbiter #(
    parameter  int DATA_WIDTH = 16,
    parameter  int M          = 32,
    parameter  int NREQ       = 4,
    parameter  int DP_LATENCY = 5,
    parameter  int RSP_DEPTH  = 8,
    localparam int W          = 2*DATA_WIDTH + $clog2(M)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*M*W-1:0]  req_a,
    input  logic [NREQ*M*W-1:0]  req_b,
    output logic                 dp_valid_in,
    output logic [M*W-1:0]       dp_vec_a,
    output logic [M*W-1:0]       dp_vec_b,
    input  logic                 dp_valid_out,
    input  logic [W-1:0]         dp_result,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [W-1:0]         rsp_data,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 err_seq
);
    localparam int TAG_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int AW    = $clog2(RSP_DEPTH);

    function automatic logic [TAG_W-1:0] rr_add(input logic [TAG_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return TAG_W'(s);
    endfunction

    function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
        return (p == CNT_W'(RSP_DEPTH-1)) ? '0 : p + CNT_W'(1);
    endfunction

    logic [TAG_W-1:0] r_rr;
    logic             r_dp_vld_p0;
    logic [M*W-1:0]   r_vec_a_p0, r_vec_b_p0;
    logic [TAG_W-1:0] r_tag_p0;
    logic [TAG_W-1:0] r_tp_tag [DP_LATENCY];
    logic [CNT_W-1:0] r_inflight, r_count, r_wr_ptr, r_rd_ptr;
    logic [W-1:0]     r_mem_data [RSP_DEPTH];
    logic [TAG_W-1:0] r_mem_tag  [RSP_DEPTH];

    logic [NREQ-1:0]  w_grant;
    logic [TAG_W-1:0] w_gnt_idx, w_head_tag;
    logic [CNT_W:0]   w_total;
    logic             w_issue, w_issue_ok, w_empty, w_full, w_pop, w_push, w_dec;

    // Credits cover both results still in the engine and results already buffered.
    assign w_total    = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_issue_ok = w_total < (CNT_W+1)'(RSP_DEPTH);

    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_issue   = 1'b0;
        if (w_issue_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_issue && req_valid[rr_add(r_rr, k)]) begin
                    w_issue   = 1'b1;
                    w_gnt_idx = rr_add(r_rr, k);
                end
            end
        end
        if (w_issue) w_grant[w_gnt_idx] = 1'b1;
    end

    assign req_ready   = w_grant;
    assign dp_valid_in = r_dp_vld_p0;
    assign dp_vec_a    = r_vec_a_p0;
    assign dp_vec_b    = r_vec_b_p0;

    // Issue stage: register the granted pair and its tag for the engine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr        <= '0;
            r_dp_vld_p0 <= 1'b0;
            r_vec_a_p0  <= '0;
            r_vec_b_p0  <= '0;
            r_tag_p0    <= '0;
        end else begin
            r_dp_vld_p0 <= w_issue;
            if (w_issue) begin
                r_rr       <= rr_add(w_gnt_idx, 1);
                r_vec_a_p0 <= req_a[int'(w_gnt_idx)*M*W +: M*W];
                r_vec_b_p0 <= req_b[int'(w_gnt_idx)*M*W +: M*W];
                r_tag_p0   <= w_gnt_idx;
            end
        end
    end

    // Tag pipe trails the issue register so its last stage coincides with dp_valid_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DP_LATENCY; i++) r_tp_tag[i] <= '0;
        end else begin
            r_tp_tag[0] <= r_tag_p0;
            for (int i = 1; i < DP_LATENCY; i++) r_tp_tag[i] <= r_tp_tag[i-1];
        end
    end

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(RSP_DEPTH));
    assign w_head_tag = r_mem_tag[r_rd_ptr[AW-1:0]];
    assign w_pop      = !w_empty && rsp_ready[w_head_tag];

`ifdef DOT_ARB_CHECK_EN
    logic r_tp_vld [DP_LATENCY];
    logic r_err;
    logic w_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DP_LATENCY; i++) r_tp_vld[i] <= 1'b0;
        end else begin
            r_tp_vld[0] <= r_dp_vld_p0;
            for (int i = 1; i < DP_LATENCY; i++) r_tp_vld[i] <= r_tp_vld[i-1];
        end
    end

    assign w_mismatch = (dp_valid_out != r_tp_vld[DP_LATENCY-1]);
    assign w_dec      = dp_valid_out && !w_mismatch;
    assign w_push     = w_dec && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else if (w_mismatch || (w_dec && w_full && !w_pop)) r_err <= 1'b1;
    end
    assign err_seq = r_err;
`else
    assign w_dec   = dp_valid_out;
    assign w_push  = dp_valid_out && (!w_full || w_pop);
    assign err_seq = 1'b0;
`endif

    // Response FIFO control; a push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            case ({w_issue, w_dec})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= dp_result;
            r_mem_tag[r_wr_ptr[AW-1:0]]  <= r_tp_tag[DP_LATENCY-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (!w_empty) begin
            rsp_valid[w_head_tag] = 1'b1;
            rsp_data              = r_mem_data[r_rd_ptr[AW-1:0]];
        end
    end
endmodule
